// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with programmable
// wait states. Requests are accepted over a valid/ready channel. The access
// (byte-lane write and/or word read) is performed on the edge that enters RESP.
// The extended load result or an error is then held until the consumer takes it.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [2:0]  reqCtrl,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspData,
  output logic        rspErr
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT       stateReg, stateNext;
  logic [3:0]  cntReg, cntNext;
  logic        writeReg;
  logic [2:0]  ctrlReg;
  logic [31:0] addrReg;
  logic [31:0] wdataReg;
  logic        errReg;

  // The request being worked on. With zero wait states the access happens on
  // the acceptance edge itself, before the latches are loaded, so in IDLE the
  // live request inputs are used instead of the latched copy.
  logic        curWrite;
  logic [2:0]  curCtrl;
  logic [31:0] curAddr;
  logic [31:0] curWData;
  logic        curErr;
  logic [IDX_W-1:0] curIdx;
  logic [3:0]  curBe;
  logic [31:0] curLaneData;
  logic        accept;
  logic        commit;
  logic [31:0] readWord;

  assign accept   = reqValid && (stateReg == IDLE);
  assign curWrite = (stateReg == IDLE) ? reqWrite : writeReg;
  assign curCtrl  = (stateReg == IDLE) ? reqCtrl  : ctrlReg;
  assign curAddr  = (stateReg == IDLE) ? reqAddr  : addrReg;
  assign curWData = (stateReg == IDLE) ? reqWData : wdataReg;
  assign curIdx   = curAddr[IDX_W+1:2];

  // The access fires only on the transition into RESP. Holding reset blocks a
  // commit even if the next-state logic is already pointing at RESP.
  assign commit = (stateNext == RESP) && (stateReg != RESP) && !reset;

  // Error classification: illegal ctrl, misalignment, out of range.
  // All three raise the same flag, so their priority only matters in that any
  // hit suppresses the write.
  always_comb begin
    logic illegal;
    logic misaligned;
    logic outOfRange;
    illegal    = curWrite ? (curCtrl > 3'd2)
                          : (curCtrl == 3'd3 || curCtrl == 3'd6 || curCtrl == 3'd7);
    misaligned = ((curCtrl[1:0] == 2'b01) && curAddr[0]) ||
                 ((curCtrl[1:0] == 2'b10) && (curAddr[1:0] != 2'b00));
    outOfRange = (32'(curAddr[31:2]) >= 32'(DEPTH_WORDS));
    curErr     = illegal || misaligned || outOfRange;
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    curBe       = 4'b0000;
    curLaneData = curWData;
    case (curCtrl[1:0])
      2'b00: begin
        curBe[curAddr[1:0]] = 1'b1;
        curLaneData = {4{curWData[7:0]}};
      end
      2'b01: begin
        curBe = curAddr[1] ? 4'b1100 : 4'b0011;
        curLaneData = {2{curWData[15:0]}};
      end
      default: curBe = 4'b1111;
    endcase
  end

  // Next-state logic and wait-state counter.
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    case (stateReg)
      IDLE: begin
        if (reqValid) begin
          if (WAIT_CYCLES == 0) begin
            stateNext = RESP;
          end else begin
            cntNext   = 4'(WAIT_CYCLES - 1);
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        if (cntReg == 4'd0) stateNext = RESP;
        else                cntNext   = cntReg - 4'd1;
      end
      RESP: begin
        if (rspReady) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg <= IDLE;
      cntReg   <= 4'd0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  // Latch the request on acceptance and capture the error flag at the access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      writeReg <= 1'b0;
      ctrlReg  <= 3'd0;
      addrReg  <= 32'd0;
      wdataReg <= 32'd0;
      errReg   <= 1'b0;
    end else begin
      if (accept) begin
        writeReg <= reqWrite;
        ctrlReg  <= reqCtrl;
        addrReg  <= reqAddr;
        wdataReg <= reqWData;
      end
      if (commit) errReg <= curErr;
    end
  end

  // One byte-wide RAM per lane, so that partial stores need no read-modify-write.
  // The registered read is taken on the commit edge.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      logic [7:0] memLane [DEPTH_WORDS];
      logic [7:0] laneRead;

      // Lane write (only for error-free stores) and registered lane read.
      always_ff @(posedge clk) begin
        if (commit && !curErr && curWrite && curBe[gi])
          memLane[curIdx] <= curLaneData[gi*8 +: 8];
        if (commit)
          laneRead <= memLane[curIdx];
      end

      assign readWord[gi*8 +: 8] = laneRead;
    end
  endgenerate

  // Response formatting: lane select and extension from the latched request.
  always_comb begin
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    byteSel = readWord[{addrReg[1:0], 3'b000} +: 8];
    halfSel = addrReg[1] ? readWord[31:16] : readWord[15:0];
    rspData = 32'd0;
    if ((stateReg == RESP) && !errReg && !writeReg) begin
      case (ctrlReg)
        3'd0:    rspData = {{24{byteSel[7]}}, byteSel};
        3'd1:    rspData = {{16{halfSel[15]}}, halfSel};
        3'd2:    rspData = readWord;
        3'd4:    rspData = {24'd0, byteSel};
        3'd5:    rspData = {16'd0, halfSel};
        default: rspData = 32'd0;
      endcase
    end
  end

  assign reqReady = (stateReg == IDLE);
  assign rspValid = (stateReg == RESP);
  assign rspErr   = rspValid && errReg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Instance A (1 wait state) covers the data
// path, the error cases and backpressure. Instance B (4 wait states) covers
// latency and an abort by reset.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        resetA, resetB;
  logic        reqValidA, reqValidB;
  logic        reqReadyA, reqReadyB;
  logic        reqWrite;
  logic [2:0]  reqCtrl;
  logic [31:0] reqAddr, reqWData;
  logic        rspValidA, rspValidB;
  logic        rspReady;
  logic [31:0] rspDataA, rspDataB;
  logic        rspErrA, rspErrB;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dutA (
    .clk(clk), .reset(resetA),
    .reqValid(reqValidA), .reqReady(reqReadyA), .reqWrite(reqWrite),
    .reqCtrl(reqCtrl), .reqAddr(reqAddr), .reqWData(reqWData),
    .rspValid(rspValidA), .rspReady(rspReady), .rspData(rspDataA), .rspErr(rspErrA)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(4)) dutB (
    .clk(clk), .reset(resetB),
    .reqValid(reqValidB), .reqReady(reqReadyB), .reqWrite(reqWrite),
    .reqCtrl(reqCtrl), .reqAddr(reqAddr), .reqWData(reqWData),
    .rspValid(rspValidB), .rspReady(rspReady), .rspData(rspDataB), .rspErr(rspErrB)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance A (sel=0) or B (sel=1). Returns the
  // response and the cycles from acceptance to rspValid.
  task automatic doReq(input bit sel, input logic w, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] data, output logic err, output int lat);
    int n;
    @(negedge clk);
    reqWrite = w; reqCtrl = ctrl; reqAddr = addr; reqWData = wdata;
    if (sel) reqValidB = 1'b1; else reqValidA = 1'b1;
    n = 0;
    while (!(sel ? reqReadyB : reqReadyA) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    reqValidA = 1'b0;
    reqValidB = 1'b0;
    lat = 0;
    while (!(sel ? rspValidB : rspValidA) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    data = sel ? rspDataB : rspDataA;
    err  = sel ? rspErrB : rspErrA;
    rspReady = 1'b1;
    @(posedge clk);
    #1 rspReady = 1'b0;
    $display("txn dut=%s w=%0b ctrl=%0d addr=%h wdata=%h -> data=%h err=%0b lat=%0d",
             sel ? "B" : "A", w, ctrl, addr, wdata, data, err, lat);
  endtask

  // Transaction plus checks of latency, data and error flag.
  task automatic txn(input string tag, input bit sel, input logic w, input logic [2:0] ctrl,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] expData, input logic expErr, input int expLat);
    logic [31:0] d;
    logic        e;
    int          l;
    doReq(sel, w, ctrl, addr, wdata, d, e, l);
    chk({tag, "_lat"}, 32'(l), 32'(expLat));
    chk({tag, "_data"}, d, expData);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, expErr});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    resetA = 1'b1; resetB = 1'b1;
    reqValidA = 1'b0; reqValidB = 1'b0; rspReady = 1'b0;
    reqWrite = 1'b0; reqCtrl = 3'd0; reqAddr = 32'd0; reqWData = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rspValid", {31'd0, rspValidA}, 32'd0);
    chk("rst_rspData", rspDataA, 32'd0);
    chk("rst_rspErr", {31'd0, rspErrA}, 32'd0);
    chk("rst_reqReady", {31'd0, reqReadyA}, 32'd1);
    @(negedge clk);
    resetA = 1'b0; resetB = 1'b0;

    // Basic store / load with width and extension variants
    txn("sw10", 0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    txn("lw10", 0, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    txn("lb13", 0, 1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
    txn("lbu13", 0, 1'b0, 3'd4, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2);
    txn("lh12", 0, 1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 2);
    txn("lhu10", 0, 1'b0, 3'd5, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 2);
    txn("lb10", 0, 1'b0, 3'd0, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 2);

    // Partial stores
    txn("sb11", 0, 1'b1, 3'd0, 32'h11, 32'h55, 32'h0, 1'b0, 2);
    txn("lw10_sb", 0, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 2);
    txn("sh12", 0, 1'b1, 3'd1, 32'h12, 32'h1234, 32'h0, 1'b0, 2);
    txn("lw10_sh", 0, 1'b0, 3'd2, 32'h10, 32'h0, 32'h123455EF, 1'b0, 2);

    // Errors
    txn("lw12_mis", 0, 1'b0, 3'd2, 32'h12, 32'h0, 32'h0, 1'b1, 2);
    txn("sh11_mis", 0, 1'b1, 3'd1, 32'h11, 32'hFFFF, 32'h0, 1'b1, 2);
    txn("lw10_keep", 0, 1'b0, 3'd2, 32'h10, 32'h0, 32'h123455EF, 1'b0, 2);
    txn("lw_oor", 0, 1'b0, 3'd2, DEPTH * 4, 32'h0, 32'h0, 1'b1, 2);
    txn("ld_ctrl3", 0, 1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1, 2);
    txn("sd_ctrl4", 0, 1'b1, 3'd4, 32'h10, 32'hAAAAAAAA, 32'h0, 1'b1, 2);
    txn("lw10_keep2", 0, 1'b0, 3'd2, 32'h10, 32'h0, 32'h123455EF, 1'b0, 2);

    // Highest legal word
    txn("sw_last", 0, 1'b1, 3'd2, DEPTH * 4 - 4, 32'h0BADF00D, 32'h0, 1'b0, 2);
    txn("lw_last", 0, 1'b0, 3'd2, DEPTH * 4 - 4, 32'h0, 32'h0BADF00D, 1'b0, 2);

    // Backpressure: response held for 5 cycles while a second request is offered
    @(negedge clk);
    reqWrite = 1'b0; reqCtrl = 3'd2; reqAddr = 32'h10; reqWData = 32'h0;
    reqValidA = 1'b1;
    @(posedge clk);
    #1 reqValidA = 1'b0;
    lat = 0;
    while (!rspValidA && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'd2);
    reqWrite = 1'b1; reqAddr = 32'h10; reqWData = 32'h0; reqValidA = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rspValid", {31'd0, rspValidA}, 32'd1);
      chk("bp_rspData", rspDataA, 32'h123455EF);
      chk("bp_reqReady", {31'd0, reqReadyA}, 32'd0);
      @(negedge clk);
    end
    reqValidA = 1'b0;
    rspReady = 1'b1;
    @(posedge clk);
    #1 rspReady = 1'b0;
    chk("bp_rel_rspValid", {31'd0, rspValidA}, 32'd0);
    chk("bp_rel_reqReady", {31'd0, reqReadyA}, 32'd1);
    $display("txn dut=A backpressure hold=5 released");
    txn("bp_ignored", 0, 1'b0, 3'd2, 32'h10, 32'h0, 32'h123455EF, 1'b0, 2);

    // Reset abort on the 4-wait-state instance
    txn("b_sw20", 1, 1'b1, 3'd2, 32'h20, 32'h11111111, 32'h0, 1'b0, 5);
    txn("b_lw20", 1, 1'b0, 3'd2, 32'h20, 32'h0, 32'h11111111, 1'b0, 5);
    @(negedge clk);
    reqWrite = 1'b1; reqCtrl = 3'd2; reqAddr = 32'h20; reqWData = 32'hCAFEF00D;
    reqValidB = 1'b1;
    @(posedge clk);
    #1 reqValidB = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b_wait_reqReady", {31'd0, reqReadyB}, 32'd0);
    resetB = 1'b1;
    #1;
    chk("b_rst_rspValid", {31'd0, rspValidB}, 32'd0);
    chk("b_rst_reqReady", {31'd0, reqReadyB}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    resetB = 1'b0;
    #1;
    chk("b_rel_reqReady", {31'd0, reqReadyB}, 32'd1);
    repeat (6) @(negedge clk);
    chk("b_rel_noRsp", {31'd0, rspValidB}, 32'd0);
    $display("txn dut=B reset abort of SW 0x20");
    txn("b_lw20_after", 1, 1'b0, 3'd2, 32'h20, 32'h0, 32'h11111111, 1'b0, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
